// File: rtl/pipe_pkg.sv
// Shared PIPE Rx definitions: sync-header codes, block layout and FSM states.
// Imported by the block FIFO and the Rx block serializer.
package pipe_pkg;

  localparam logic [1:0] SYNC_HDR_DATA = 2'b10;
  localparam logic [1:0] SYNC_HDR_OS   = 2'b01;

  localparam int BLOCK_BYTES     = 16;
  localparam int WORDS_PER_BLOCK = 4;

  typedef struct packed {
    logic [1:0]   hdr;
    logic [127:0] data;
  } pipe_block_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } ser_state_e;

  function automatic logic hdr_invalid(input logic [1:0] h);
    return (h != SYNC_HDR_DATA) && (h != SYNC_HDR_OS);
  endfunction

endpackage

// File: rtl/pipe_block_fifo.sv
// Synchronous FIFO of 130-bit blocks with full/empty/level status.
// Pointers carry one extra MSB so full and empty are distinguishable.
module pipe_block_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  pipe_block_t            wdata,
  output pipe_block_t            rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  pipe_block_t     mem_q [DEPTH];
  logic [AW:0]     wptr_q, wptr_d;
  logic [AW:0]     rptr_q, rptr_d;
  logic            do_push;
  logic            do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level   = wptr_q - rptr_q;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pipe_rx_block_serializer.sv
// Buffers 128b/130b blocks and serialises them onto the 32-bit PIPE Rx path.
// Define PIPE_RX_SYNC_HDR_CHECK_EN to add the sticky hdr_err output.
module pipe_rx_block_serializer
  import pipe_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   blk_valid,
  output logic                   blk_ready,
  input  logic [1:0]             blk_sync_hdr,
  input  logic [127:0]           blk_data,
  input  logic                   rx_enable,
  output logic [DATA_W-1:0]      RxData,
  output logic [3:0]             RxDataK,
  output logic                   RxValid,
  output logic                   RxStartBlock,
  output logic [3:0]             RxSyncHeader,
`ifdef PIPE_RX_SYNC_HDR_CHECK_EN
  output logic                   hdr_err,
`endif
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int LW = $clog2(DEPTH) + 1;

  pipe_block_t       wr_blk;
  pipe_block_t       head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              emit;
  logic [LW-1:0]     level;

  ser_state_e        state_q;
  logic [1:0]        wcnt_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              rx_start_q;
  logic [3:0]        rx_sync_q;

  assign blk_ready = !full && !reset;
  assign push      = blk_valid && blk_ready;
  assign wr_blk    = '{hdr: blk_sync_hdr, data: blk_data};

  // Word 0 is emitted straight out of IDLE so a fresh block costs no bubble.
  assign emit = !empty && rx_enable;
  assign pop  = emit && (wcnt_q == 2'd3);

  pipe_block_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_blk),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_start_q <= 1'b0;
      rx_sync_q  <= '0;
    end else begin
      rx_valid_q <= emit;
      rx_start_q <= emit && (wcnt_q == 2'd0);
      if (emit) begin
        rx_data_q <= head.data[DATA_W*int'(wcnt_q) +: DATA_W];
        wcnt_q    <= wcnt_q + 2'd1;
        if (wcnt_q == 2'd0) rx_sync_q <= {2'b00, head.hdr};
      end
      unique case (state_q)
        ST_IDLE: if (emit) state_q <= ST_SEND;
        ST_SEND: begin
          if (pop && (level == LW'(1)) && !push)
            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PIPE_RX_SYNC_HDR_CHECK_EN
  logic hdr_err_q;

  always_ff @(posedge clk) begin
    if (reset)
      hdr_err_q <= 1'b0;
    else if (push && hdr_invalid(blk_sync_hdr))
      hdr_err_q <= 1'b1;
  end

  assign hdr_err = hdr_err_q;
`endif

  assign RxData       = rx_data_q;
  assign RxDataK      = 4'b0000;
  assign RxValid      = rx_valid_q;
  assign RxStartBlock = rx_start_q;
  assign RxSyncHeader = rx_sync_q;
  assign fifo_level   = level;

endmodule
